// File: rtl/pixel_source.sv
// Purpose: streams a stored greyscale frame from sync RAM as a gap-free pixel bus with frame/line markers.
// Latency: Start sampled at edge k -> first read after k+1 -> first pixel with markers after k+3.
// Backpressure: none; consumers must accept one pixel per clock while a frame is in flight.
module pixel_source #(
    parameter int ADDR_W = 16,
    parameter int VGAP   = 4
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Start,
    input  logic              Continuous,
    input  logic [7:0]        Width,
    input  logic [7:0]        Height,
    output logic              MemRd,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [7:0]        MemData,
    output logic [7:0]        PixelOut,
    output logic              FrameOut,
    output logic              LineOut,
    output logic              Busy,
    output logic              Done
);

    localparam int GAP_W = $clog2(VGAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [7:0]          width_q, width_d;
    logic [7:0]          height_q, height_d;
    logic [7:0]          col_q, col_d;
    logic [7:0]          row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                busy_q;

    // Read stage: strobe, address and tags issued together with the RAM read.
    logic                rd_vld_q, rd_vld_d;
    logic                rd_frm_q, rd_frm_d;
    logic                rd_line_q, rd_line_d;
    logic                rd_last_q, rd_last_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    // Delay stage: tags aligned with the cycle MemData is valid.
    logic                dl_vld_q, dl_frm_q, dl_line_q, dl_last_q;

    // Output register.
    logic [7:0]          pixel_q;
    logic                frame_q, line_q, done_q;

    logic                last_rd;
    logic                dims_ok;

    assign last_rd = (row_q == height_q - 8'd1) && (col_q == width_q - 8'd1);
    assign dims_ok = (Width != 8'd0) && (Height != 8'd0);

    // Next-state logic: frame sequencing, raster counters and read issue.
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        gap_d      = gap_q;
        rd_vld_d   = 1'b0;
        rd_frm_d   = 1'b0;
        rd_line_d  = 1'b0;
        rd_last_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        case (state_q)
            S_IDLE: begin
                if (Start && dims_ok) begin
                    width_d  = Width;
                    height_d = Height;
                    col_d    = 8'd0;
                    row_d    = 8'd0;
                    addr_d   = '0;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                rd_vld_d   = 1'b1;
                mem_addr_d = addr_q;
                rd_frm_d   = (addr_q == '0);
                rd_line_d  = (col_q == 8'd0);
                rd_last_d  = last_rd;
                addr_d     = addr_q + ADDR_W'(1);
                if (last_rd) begin
                    gap_d   = GAP_W'(VGAP);
                    state_d = S_GAP;
                end else if (col_q == width_q - 8'd1) begin
                    col_d = 8'd0;
                    row_d = row_q + 8'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            S_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    // A zero-sized relatch would never terminate, so fall back to IDLE.
                    if (Continuous && dims_ok) begin
                        width_d  = Width;
                        height_d = Height;
                        col_d    = 8'd0;
                        row_d    = 8'd0;
                        addr_d   = '0;
                        state_d  = S_STREAM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, counters and read-stage registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            width_q    <= 8'd0;
            height_q   <= 8'd0;
            col_q      <= 8'd0;
            row_q      <= 8'd0;
            addr_q     <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_frm_q   <= 1'b0;
            rd_line_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            gap_q      <= gap_d;
            busy_q     <= (state_q != S_IDLE);
            rd_vld_q   <= rd_vld_d;
            rd_frm_q   <= rd_frm_d;
            rd_line_q  <= rd_line_d;
            rd_last_q  <= rd_last_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Tag delay matching RAM latency, then the registered pixel/marker outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            dl_vld_q  <= 1'b0;
            dl_frm_q  <= 1'b0;
            dl_line_q <= 1'b0;
            dl_last_q <= 1'b0;
            pixel_q   <= 8'd0;
            frame_q   <= 1'b0;
            line_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            dl_vld_q  <= rd_vld_q;
            dl_frm_q  <= rd_vld_q & rd_frm_q;
            dl_line_q <= rd_vld_q & rd_line_q;
            dl_last_q <= rd_vld_q & rd_last_q;
            pixel_q   <= dl_vld_q ? MemData : 8'd0;
            frame_q   <= dl_vld_q & dl_frm_q;
            line_q    <= dl_vld_q & dl_line_q;
            done_q    <= dl_vld_q & dl_last_q;
        end
    end

    assign MemRd    = rd_vld_q;
    assign MemAddr  = mem_addr_q;
    assign PixelOut = pixel_q;
    assign FrameOut = frame_q;
    assign LineOut  = line_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_pixel_source.sv
module tb_pixel_source;

    localparam int VGAP = 4;

    logic        clk;
    logic        n_reset;
    logic        start;
    logic        continuous;
    logic [7:0]  width;
    logic [7:0]  height;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  pixel_out;
    logic        frame_out;
    logic        line_out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    logic [15:0] prev_addr;

    pixel_source #(.ADDR_W(16), .VGAP(VGAP)) dut (
        .Clk        (clk),
        .nReset     (n_reset),
        .Start      (start),
        .Continuous (continuous),
        .Width      (width),
        .Height     (height),
        .MemRd      (mem_rd),
        .MemAddr    (mem_addr),
        .MemData    (mem_data),
        .PixelOut   (pixel_out),
        .FrameOut   (frame_out),
        .LineOut    (line_out),
        .Busy       (busy),
        .Done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM whose content is RAM[a] = a (low byte).
    always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0];

    wire [28:0] obs = {mem_rd, mem_addr, pixel_out, frame_out, line_out, busy, done};

    // Expected {MemRd, MemAddr, PixelOut, FrameOut, LineOut, Busy, Done} c cycles after the
    // edge that sampled Start, for a single (non-continuous) frame of w x h.
    function automatic logic [28:0] exp_frame(int c, int w, int h, logic [15:0] prev);
        int n = w * h;
        int i = c - 3;
        logic rd, fo, lo, bs, dn;
        logic [15:0] a;
        logic [7:0] px;
        rd = (c >= 1) && (c <= n);
        a  = (c < 1) ? prev : ((c <= n) ? 16'(c - 1) : 16'(n - 1));
        px = 8'd0; fo = 1'b0; lo = 1'b0; dn = 1'b0;
        if (i >= 0 && i < n) begin
            px = 8'(i);
            fo = (i == 0);
            lo = ((i % w) == 0);
            dn = (i == n - 1);
        end
        bs = (c >= 1) && (c <= n + VGAP);
        return {rd, a, px, fo, lo, bs, dn};
    endfunction

    // Pulse Start for one edge; returns at the negedge just after the sampling edge (c = 0).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        start = 1'b0; continuous = 1'b0; width = 8'd4; height = 8'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 29'd0) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", obs, 29'd0);
        end
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 29'd0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", obs, 29'd0);
        end
        prev_addr = 16'd0;
    endtask

    task automatic test_basic_frame();
        logic [28:0] e;
        width = 8'd4; height = 8'd3; continuous = 1'b0;
        pulse_start();
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) @(negedge clk);
            e = exp_frame(c, 4, 3, prev_addr);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL basic_4x3 c=%0d got=%h exp=%h", c, obs, e);
            end
        end
        prev_addr = 16'd11;
    endtask

    task automatic test_continuous();
        logic [28:0] e;
        logic rd, fo, lo, dn;
        logic [15:0] a;
        logic [7:0] px;
        int cp, i, p;
        bit seen_idle;
        width = 8'd2; height = 8'd2; continuous = 1'b1;
        pulse_start();
        for (int c = 0; c <= 26; c++) begin
            if (c > 0) @(negedge clk);
            cp = (c >= 1) ? (c - 1) % (4 + VGAP) : 0;
            rd = (c >= 1) && (cp < 4);
            a  = (c < 1) ? prev_addr : ((cp < 4) ? 16'(cp) : 16'd3);
            i  = c - 3;
            px = 8'd0; fo = 1'b0; lo = 1'b0; dn = 1'b0;
            if (i >= 0) begin
                p = i % (4 + VGAP);
                if (p < 4) begin
                    px = 8'(p);
                    fo = (p == 0);
                    lo = (p == 0) || (p == 2);
                    dn = (p == 3);
                end
            end
            e = {rd, a, px, fo, lo, (c >= 1), dn};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL continuous_2x2 c=%0d got=%h exp=%h", c, obs, e);
            end
        end
        continuous = 1'b0;
        seen_idle = 1'b0;
        for (int k = 0; k < 40 && !seen_idle; k++) begin
            @(negedge clk);
            if (busy === 1'b0) seen_idle = 1'b1;
        end
        checks++;
        if (!seen_idle || mem_rd !== 1'b0 || mem_addr !== 16'd3) begin
            failures++;
            $display("FAIL continuous_stop idle=%0d rd=%b addr=%0d exp idle=1 rd=0 addr=3",
                     seen_idle, mem_rd, mem_addr);
        end
        prev_addr = 16'd3;
    endtask

    task automatic test_ignore_mid_frame();
        logic [28:0] e;
        width = 8'd5; height = 8'd3; continuous = 1'b0;
        pulse_start();
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) @(negedge clk);
            e = exp_frame(c, 5, 3, prev_addr);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL mid_frame_ignore c=%0d got=%h exp=%h", c, obs, e);
            end
            if (c == 6) begin
                start = 1'b1;
                width = 8'd9;
            end
            if (c == 8) start = 1'b0;
        end
        prev_addr = 16'd14;
    endtask

    task automatic test_zero_dims();
        logic [28:0] e;
        e = {1'b0, prev_addr, 8'd0, 4'b0000};
        width = 8'd0; height = 8'd3;
        pulse_start();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL zero_width c=%0d got=%h exp=%h", c, obs, e);
            end
        end
        width = 8'd3; height = 8'd0;
        pulse_start();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL zero_height c=%0d got=%h exp=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [28:0] e;
        width = 8'd4; height = 8'd3;
        pulse_start();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            e = exp_frame(c, 4, 3, prev_addr);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL pre_reset c=%0d got=%h exp=%h", c, obs, e);
            end
        end
        n_reset = 1'b0;
        #1;
        checks++;
        if (obs !== 29'd0) begin
            failures++;
            $display("FAIL async_reset_immediate got=%h exp=%h", obs, 29'd0);
        end
        @(negedge clk);
        n_reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 29'd0) begin
                failures++;
                $display("FAIL after_reset_quiet c=%0d got=%h exp=%h", c, obs, 29'd0);
            end
        end
        prev_addr = 16'd0;
        pulse_start();
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) @(negedge clk);
            e = exp_frame(c, 4, 3, prev_addr);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL restart_after_reset c=%0d got=%h exp=%h", c, obs, e);
            end
        end
        prev_addr = 16'd11;
    endtask

    task automatic test_max_frame();
        int n = 255 * 255;
        int mism = 0, lines = 0, frames = 0, dones = 0, done_c = -1;
        logic [15:0] max_addr = 16'd0;
        logic [28:0] e;
        width = 8'd255; height = 8'd255;
        pulse_start();
        for (int c = 0; c <= n + VGAP + 8; c++) begin
            if (c > 0) @(negedge clk);
            e = exp_frame(c, 255, 255, prev_addr);
            if (obs !== e) mism++;
            if (line_out === 1'b1) lines++;
            if (frame_out === 1'b1) frames++;
            if (done === 1'b1) begin
                dones++;
                done_c = c;
            end
            if (mem_rd === 1'b1 && mem_addr > max_addr) max_addr = mem_addr;
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL max_frame_stream mismatching_cycles=%0d exp=0", mism);
        end
        checks++;
        if (max_addr !== 16'd65024) begin
            failures++;
            $display("FAIL max_frame_last_addr got=%0d exp=65024", max_addr);
        end
        checks++;
        if (lines != 255 || frames != 1) begin
            failures++;
            $display("FAIL max_frame_markers lines=%0d frames=%0d exp 255/1", lines, frames);
        end
        checks++;
        if (dones != 1 || done_c != n + 2) begin
            failures++;
            $display("FAIL max_frame_done count=%0d at=%0d exp 1 at %0d", dones, done_c, n + 2);
        end
    endtask

    task automatic test_single_pixel();
        logic [28:0] e;
        width = 8'd1; height = 8'd1;
        pulse_start();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            e = exp_frame(c, 1, 1, prev_addr);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL single_pixel c=%0d got=%h exp=%h", c, obs, e);
            end
        end
        prev_addr = 16'd0;
    endtask

    initial begin
        mem_data = 8'd0;
        test_reset();
        test_basic_frame();
        test_continuous();
        test_ignore_mid_frame();
        test_zero_dims();
        test_reset_mid_frame();
        test_single_pixel();
        test_max_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_source.md
# pixel_source

Frame transmitter for the pixel-stream bus used by the Hough pipeline. It reads a stored greyscale image from a synchronous single-port RAM and emits it one pixel per clock, gap-free within a frame. Frame-start and line-start markers are aligned with the first pixel of each frame and each line. It sits at the head of the pipeline and drives the edge-detection stage and later consumers, which rely on contiguous lines for their line-delay buffers.

## Interface
- ADDR_W, 16, RAM address width; must satisfy 2^ADDR_W ≥ 255·255.
- VGAP, 4, idle cycles between the last read of one frame and the first read of the next; minimum 2.

- Clk  in  1  sole clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Start  in  1  request one frame; sampled only in IDLE.
- Continuous  in  1  when 1 at end of GAP, start the next frame automatically.
- Width  in  8  pixels per line; latched at frame start.
- Height  in  8  lines per frame; latched at frame start.
- MemRd  out  1  RAM read strobe.
- MemAddr  out  ADDR_W  RAM read address.
- MemData  in  8  RAM read data, valid the cycle after MemRd.
- PixelOut  out  8  pixel value; 0 when no pixel is valid.
- FrameOut  out  1  high with the first pixel of a frame.
- LineOut  out  1  high with the first pixel of every line, including line 0.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle pulse with the last pixel of a frame.

## Operation
- Reset values: MemRd=0, MemAddr=0, PixelOut=0, FrameOut=0, LineOut=0, Busy=0, Done=0. State is IDLE and the marker/valid pipeline is cleared.
- FSM has three states: IDLE, STREAM, GAP.
- IDLE:
  - Start=1 with Width≠0 and Height≠0 → latch Width/Height, clear column, row and address counters, go to STREAM.
  - Start with Width=0 or Height=0 is ignored; the block stays in IDLE.
- STREAM:
  - Every cycle, MemRd=1 and MemAddr = current address; the address increments by 1.
  - Column counter wraps at Width−1; the row counter then increments.
  - The read issued at row=Height−1, column=Width−1 is the last read → go to GAP, load the gap counter with VGAP.
- GAP:
  - MemRd=0 and MemAddr holds.
  - When the counter expires: Continuous=1 → relatch Width/Height, go to STREAM from address 0; otherwise go to IDLE.
- Start is ignored outside IDLE. Width and Height changes are ignored mid-frame.
- Read tags (valid, first-of-frame, first-of-line, last) travel in a 2-stage pipe matched to RAM latency plus the output register.
- PixelOut is registered from MemData when the tag is valid, else 0. FrameOut, LineOut and Done are registered from their tags.
- Address arithmetic uses an incrementing counter only, no multiplier. The maximum address is 65024.
- Reset mid-frame: everything returns to reset values at once. In-flight tags are discarded, so no stray marker or Done appears after release. The next frame needs a new Start and begins at address 0.

## Timing
- Start sampled at edge k → MemRd=1, MemAddr=0 after edge k+1 → first PixelOut with FrameOut=1 and LineOut=1 after edge k+3. Latency is 3 cycles.
- The frame occupies Width·Height consecutive output cycles with no gaps.
- LineOut fires at pixel indices 0, Width, 2·Width, and so on.
- Done coincides with pixel Width·Height−1.
- Busy rises after edge k+1 and falls when GAP exits to IDLE. With VGAP ≥ 2, Busy covers the last pixel output.
- Continuous mode: exactly VGAP cycles separate one frame's last pixel from the next frame's first pixel. During those cycles PixelOut=0 and all markers are low.
- Single-pixel frame (Width=Height=1): FrameOut, LineOut and Done are all high in the same cycle.

## Test plan
- Width=4, Height=3, RAM[a]=a, Start pulse → PixelOut=0..11 on 12 consecutive cycles starting 3 cycles after Start. FrameOut high at pixel 0 only, LineOut high at pixels 0/4/8, Done high at pixel 11, Busy falls VGAP cycles after the last read.
- Continuous=1, Width=2, Height=2 → repeating frames with pixels 0,1,2,3. Exactly VGAP idle cycles separate frames (PixelOut=0, markers 0), and MemAddr restarts at 0 each frame.
- Start pulse mid-frame, and Width changed 5→9 mid-frame → no restart, and the current frame keeps Width=5.
- Start with Width=0 (Height=3), then with Height=0 (Width=3) → no MemRd, Busy stays 0, no markers.
- nReset asserted at pixel 5 of a 4×3 frame → all outputs 0 at once; after release, no output until a new Start, which then emits pixel 0 with FrameOut.
- Width=Height=255 → 65025 pixels, final MemAddr=65024, 255 LineOut pulses, one FrameOut, and a single-cycle Done with the last pixel.
